mc_cfg_loader: RTL
==================

Name: mc_cfg_loader

Overview:
Serial configuration loader for the macrocell array. Accepts a fuse-style bitstream one bit per cycle over a valid/ready handshake and assembles it in a shadow register. On a complete, valid frame it commits all per-macrocell mux selects atomically to the active configuration. The active configuration drives the select inputs of every macrocell, including the pt1–pt5 sections, the xor nest, the output piece, the dff, and the goe/gclk/gclr selectors.

Parameters:
NUM_MC, 16, number of macrocells configured.
CFG_W, 19, config bits per macrocell; fixed by the package layout.

Ports:
clk  input  1  clock
ar  input  1  asynchronous reset, active-high
start  input  1  pulse; begins a frame load when the block is idle
abort  input  1  abandons the load in progress
sdi  input  1  serial config bit
sdi_valid  input  1  sdi is valid this cycle
sdi_ready  output  1  loader accepts a bit this cycle
cfg  output  NUM_MC*CFG_W  active configuration; macrocell m occupies bits [m*CFG_W +: CFG_W]
busy  output  1  a frame is in progress
done  output  1  one-cycle pulse on commit
err  output  1  sticky error flag; cleared by the next start

Behaviour:
- Reset (ar=1, asynchronous):
  - state=IDLE, cfg=0, shadow=0, bit counter=0.
  - sdi_ready=0, busy=0, done=0, err=0.
  - cfg=0 means every mux is at its select-0 default and oe_mux=000, i.e. all outputs disabled.
- States: IDLE, SHIFT, CHECK (present only with the feature), COMMIT.
- IDLE:
  - sdi_ready=0.
  - start=1 -> go to SHIFT, clear counter, clear err.
  - sdi_valid is ignored.
- SHIFT:
  - sdi_ready=1, busy=1.
  - A bit transfers on a cycle with sdi_valid & sdi_ready.
  - Transfer k (0-based) writes shadow[k]: LSB first, macrocell 0 first.
  - Counter increments per transfer. No transfer means no change; stalls of any length are allowed.
  - On the transfer with k = NUM_MC*CFG_W-1, go to COMMIT (or to CHECK with the feature).
- COMMIT: lasts one cycle.
  - cfg <= shadow; done=1 in that cycle; sdi_ready=0.
  - Next state is IDLE.
  - Frame latency: start -> done = NUM_MC*CFG_W + 2 cycles with no stalls.
- abort (any state other than IDLE or COMMIT):
  - Go to IDLE next cycle; cfg unchanged; err=1.
  - abort during COMMIT is ignored; the commit completes.
- start while busy is ignored.
- Simultaneous start and abort in IDLE: start wins, abort is ignored.
- ar during SHIFT: everything returns to reset values, including cfg.
- Per-macrocell field layout: see the package constants. Field gclk_mux uses encodings 11/00/10; code 01 is legal and selects ground.

Optional Feature:
Macro MC_CFG_CRC_EN.
- Defined:
  - After the config bits, SHIFT accepts 8 more bits: a CRC-8, polynomial 0x07, init 0x00, computed MSB-first over the config bits in transfer order.
  - Transfer order of the CRC bits: bit 7 first.
  - CHECK lasts one cycle and compares the received CRC with the running CRC.
  - Match -> COMMIT.
  - Mismatch -> IDLE with err=1, cfg unchanged, no done pulse.
  - Latency becomes NUM_MC*CFG_W + 8 + 3 cycles.
- Undefined: no CRC bits and no CHECK state; the frame is exactly NUM_MC*CFG_W bits.

Decomposition:
- Package mc_cfg_pkg holds:
  - the state enum;
  - the CFG_W value;
  - field offsets within a macrocell word:
    - PT1=0, PT2=1, PT3=2, PT4=3, PT4_FUNC=4, PT5=5, PT5_FUNC=6
    - XOR_A=7, XOR_B=8, XOR_INV=9
    - O_MUX=10, D_MUX=11, STORAGE=12
    - OE=13..15, GCLK=16..17, GCLR=18
  - CRC_POLY=8'h07.
- One sub-module, mc_cfg_crc8: serial CRC-8 update with an enable input. It is instantiated only under MC_CFG_CRC_EN.

Test Plan:
- Reset mid-frame: start, shift 100 bits, pulse ar -> cfg=0, busy=0, sdi_ready=0 immediately (asynchronously).
- Walking one, NUM_MC=16, no stalls: frame with only bit 18 set -> done exactly at cycle 306 after start; only the gclr field of macrocell 0 =1; everything else 0.
- Field placement: frame with macrocell 5 oe_mux=3'b111 (bits 108..110) -> cfg[110:108]=111; other bits 0.
- Stalls: random sdi_valid gaps at 30% density -> same committed cfg as with no stalls; done only after 304 accepted bits.
- Abort: abort after 200 bits on a prior config of all ones -> cfg remains all ones; err=1; no done; next start clears err.
- CRC (MC_CFG_CRC_EN): correct CRC -> commit; same frame with one flipped CRC bit -> err=1, no done, cfg unchanged.

Source files
------------

// File: rtl/mc_cfg_pkg.sv
// Shared definitions for the macrocell configuration loader: FSM states,
// per-macrocell word width, field offsets inside a macrocell word and the
// CRC-8 polynomial. The CHECK state exists only when MC_CFG_CRC_EN is defined.
package mc_cfg_pkg;

  localparam int MC_CFG_W = 19;

  // Field offsets within one macrocell configuration word
  localparam int PT1       = 0;
  localparam int PT2       = 1;
  localparam int PT3       = 2;
  localparam int PT4       = 3;
  localparam int PT4_FUNC  = 4;
  localparam int PT5       = 5;
  localparam int PT5_FUNC  = 6;
  localparam int XOR_A     = 7;
  localparam int XOR_B     = 8;
  localparam int XOR_INV   = 9;
  localparam int O_MUX     = 10;
  localparam int D_MUX     = 11;
  localparam int STORAGE   = 12;
  localparam int OE_LSB    = 13;
  localparam int OE_MSB    = 15;
  localparam int GCLK_LSB  = 16;
  localparam int GCLK_MSB  = 17;
  localparam int GCLR      = 18;

  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
`ifdef MC_CFG_CRC_EN
    ,
    ST_CHECK  = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/mc_cfg_crc8.sv
// Serial CRC-8 (polynomial from mc_cfg_pkg, init 0), one message bit per
// enabled cycle, MSB-first. Used by mc_cfg_loader only when MC_CFG_CRC_EN
// is defined.
module mc_cfg_crc8
  import mc_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       ar,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[7] ^ din;

  // Shift the running remainder, folding in the polynomial when the feedback bit is set
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/mc_cfg_loader.sv
// Serial configuration loader for the macrocell array. Bits arrive LSB
// first, macrocell 0 first, over a valid/ready handshake into a shadow
// register; a complete frame is copied to cfg in a single cycle so every
// macrocell select changes together. Define MC_CFG_CRC_EN to append a
// CRC-8 trailer to the frame and verify it before committing.
module mc_cfg_loader
  import mc_cfg_pkg::*;
#(
  parameter int NUM_MC = 16,
  parameter int CFG_W  = MC_CFG_W
) (
  input  logic                    clk,
  input  logic                    ar,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    sdi,
  input  logic                    sdi_valid,
  output logic                    sdi_ready,
  output logic [NUM_MC*CFG_W-1:0] cfg,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int FRAME_BITS = NUM_MC * CFG_W;
`ifdef MC_CFG_CRC_EN
  localparam int TOTAL_BITS = FRAME_BITS + 8;
`else
  localparam int TOTAL_BITS = FRAME_BITS;
`endif
  localparam int CNT_W = $clog2(TOTAL_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(TOTAL_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_BITS);

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [FRAME_BITS-1:0]   shadow;
  logic                    xfer;
  logic                    load_start;
  logic                    crc_ok;

  // A bit moves only when the loader is shifting and no abort overrides it
  assign xfer       = sdi_valid & sdi_ready & ~abort;
  assign load_start = (state == ST_IDLE) & start;

`ifdef MC_CFG_CRC_EN
  logic [7:0] crc_calc;
  logic [7:0] crc_rx;
  logic       crc_en;

  assign crc_en = xfer & (cnt < FRAME_END);
  assign crc_ok = (crc_rx == crc_calc);

  mc_cfg_crc8 u_crc8 (
    .clk (clk),
    .ar  (ar),
    .clr (load_start),
    .en  (crc_en),
    .din (sdi),
    .crc (crc_calc)
  );

  // Collect the received CRC trailer, bit 7 first
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      crc_rx <= '0;
    end else if (xfer && (cnt >= FRAME_END)) begin
      crc_rx <= {crc_rx[6:0], sdi};
    end
  end
`else
  assign crc_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start beats abort in IDLE, abort is ignored in COMMIT
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (sdi_valid && (cnt == LAST_IDX)) begin
`ifdef MC_CFG_CRC_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_COMMIT;
`endif
        end
      end
`ifdef MC_CFG_CRC_EN
      ST_CHECK: begin
        if (abort)       state_nxt = ST_IDLE;
        else if (crc_ok) state_nxt = ST_COMMIT;
        else             state_nxt = ST_IDLE;
      end
`endif
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    sdi_ready = (state == ST_SHIFT);
    busy      = (state != ST_IDLE);
    done      = (state == ST_COMMIT);
  end

  // Bit counter and shadow register fill
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (load_start) begin
      cnt <= '0;
    end else if (xfer) begin
      cnt <= cnt + 1'b1;
      if (cnt < FRAME_END) shadow[cnt] <= sdi;
    end
  end

  // Active configuration: replaced as a whole on commit only
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      cfg <= '0;
    end else if (state == ST_COMMIT) begin
      cfg <= shadow;
    end
  end

  // Sticky error: set by abort or CRC mismatch, cleared by an accepted start
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      err <= 1'b0;
    end else if (load_start) begin
      err <= 1'b0;
    end else if (abort && (state != ST_IDLE) && (state != ST_COMMIT)) begin
      err <= 1'b1;
`ifdef MC_CFG_CRC_EN
    end else if ((state == ST_CHECK) && !crc_ok) begin
      err <= 1'b1;
`endif
    end
  end

endmodule
